cache_req_arbiter: RTL and testbench
====================================

// Module: cache_req_arbiter
//
// PURPOSE
//   Arbitrates between L1-side requests and bus-snoop requests for the single L2
//   MESI state-machine datapath. It holds one command at a time in flight.
//   It latches the winning request, drives one valid pulse with msg/addr into the
//   MESI FSM, and waits for completion before accepting the next request.
//   It sits between the L1/snoop request sources and the cache MESI FSM.
//
// PARAMETERS
//   MSG_W             4   width of request message code (n_struct encoding)
//   ADDR_W            32  request address width
//   MAX_SNOOP_STREAK  4   consecutive snoop grants allowed while L1 waits (>=1)
//   TIMEOUT_CYC       16  WAIT-state watchdog limit, cycles (used only with macro)
//
// PORTS
//   clk            in   1       clock, all flops on posedge
//   rst            in   1       asynchronous, active-high reset
//   l1_req_valid   in   1       L1 request present
//   l1_req_ready   out  1       L1 request accepted this cycle (valid&ready)
//   l1_req_msg     in   MSG_W   L1 message (READ_REQ_L1_D, WRITE_REQ_L1_D, ...)
//   l1_req_addr    in   ADDR_W  L1 request address
//   snp_req_valid  in   1       snoop request present
//   snp_req_ready  out  1       snoop request accepted this cycle
//   snp_req_msg    in   MSG_W   snoop message (SNOOP_READ_REQ, SNOOP_INVALID_CMD, ...)
//   snp_req_addr   in   ADDR_W  snoop address
//   fsm_valid      out  1       one-cycle command strobe to MESI FSM
//   fsm_msg        out  MSG_W   latched message; stable from issue until done
//   fsm_addr       out  ADDR_W  latched address; stable from issue until done
//   fsm_done       in   1       one-cycle pulse: FSM outputs have been updated
//   grant_src      out  1       source of the in-flight command: 0 = L1, 1 = snoop
//   busy           out  1       high in ISSUE and WAIT
//   timeout_err    out  1       one-cycle pulse when the watchdog expires
//
// BEHAVIOUR
//   - Reset: state = IDLE; fsm_valid, fsm_msg, fsm_addr, grant_src, busy,
//     timeout_err and the streak/timeout counters are all 0; both readies are 0.
//   - Reset asserted mid-operation aborts the command. No fsm_valid is issued
//     after reset.
//   - States and transitions:
//     - IDLE: if any valid, pick a winner. The winner's ready = 1 in that cycle only;
//       its msg/addr and grant_src are latched; next state is ISSUE.
//       Readies are combinational and are high only in IDLE.
//     - ISSUE: fsm_valid = 1 for exactly one cycle, then WAIT. fsm_done is ignored here.
//     - WAIT: on fsm_done go to IDLE. fsm_done is ignored in IDLE.
//   - Latency: accept at cycle N -> fsm_valid at N+1 -> earliest done N+2.
//     The next accept is possible at done+1.
//   - Priority: snoop wins by default.
//     - Exception: L1 wins if l1_req_valid and streak == MAX_SNOOP_STREAK.
//     - streak increments (saturating) on a snoop grant while l1_req_valid = 1.
//     - streak clears on an L1 grant.
//   - Simultaneous valids: only the winner sees ready. The loser must hold
//     its request stable.
//   - Requester valid dropping while not granted is legal; nothing is latched.
//
// CONFIGURATION
//   ARB_TIMEOUT_EN defined:
//     - A counter runs in WAIT and clears on entry to WAIT.
//     - If TIMEOUT_CYC cycles pass without fsm_done: timeout_err pulses one cycle,
//       the FSM returns to IDLE, and the command is dropped.
//     - fsm_done arriving in the same cycle as expiry wins; no error is raised.
//   ARB_TIMEOUT_EN undefined:
//     - No counter; WAIT lasts until fsm_done.
//     - timeout_err is tied to 0.
//
// TESTING
//   1. L1 only, msg=READ_REQ_L1_D, addr=0x100 at cycle 0, done at cycle 3
//      -> l1_req_ready @0; fsm_valid @1 with 0x100; busy @1-3; low @4.
//   2. L1 and snoop valid together at cycle 0
//      -> snp_req_ready @0, grant_src = 1; L1 accepted on the cycle after done.
//   3. Snoops back-to-back with L1 pending, MAX_SNOOP_STREAK = 2
//      -> grant order S, S, L1, S, S, L1.
//   4. rst pulsed during WAIT
//      -> next cycle: IDLE, busy = 0, fsm_valid = 0; a pending request is
//         re-accepted after rst falls.
//   5. With ARB_TIMEOUT_EN, TIMEOUT_CYC = 16, no done after issue
//      -> timeout_err pulses after 16 WAIT cycles, then IDLE.
//      Without the macro: busy stays 1.
//   6. Spurious fsm_done while IDLE, and fsm_done in ISSUE
//      -> ignored: no state change; the command still completes on a later done.

Source files
------------

// File: rtl/cache_req_arbiter.sv
// Single-command arbiter between L1 and snoop requests feeding the L2 MESI FSM.
// Optional WAIT-state watchdog enabled by defining ARB_TIMEOUT_EN.
module cache_req_arbiter #(
  parameter int unsigned MSG_W            = 4,
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned MAX_SNOOP_STREAK = 4,
  parameter int unsigned TIMEOUT_CYC      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              l1_req_valid,
  output logic              l1_req_ready,
  input  logic [MSG_W-1:0]  l1_req_msg,
  input  logic [ADDR_W-1:0] l1_req_addr,
  input  logic              snp_req_valid,
  output logic              snp_req_ready,
  input  logic [MSG_W-1:0]  snp_req_msg,
  input  logic [ADDR_W-1:0] snp_req_addr,
  output logic              fsm_valid,
  output logic [MSG_W-1:0]  fsm_msg,
  output logic [ADDR_W-1:0] fsm_addr,
  input  logic              fsm_done,
  output logic              grant_src,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned STREAK_W = $clog2(MAX_SNOOP_STREAK + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [MSG_W-1:0]    msg_q, msg_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                src_q, src_d;
  logic                valid_q, valid_d;
  logic                busy_q, busy_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                snp_wins_c;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_err_q, to_err_d;
`endif

  // Snoop wins unless L1 has been starved for MAX_SNOOP_STREAK snoop grants.
  assign snp_wins_c = snp_req_valid &&
                      !(l1_req_valid && (streak_q == STREAK_W'(MAX_SNOOP_STREAK)));

  always_comb begin
    state_d       = state_q;
    msg_d         = msg_q;
    addr_d        = addr_q;
    src_d         = src_q;
    valid_d       = 1'b0;
    busy_d        = busy_q;
    streak_d      = streak_q;
    l1_req_ready  = 1'b0;
    snp_req_ready = 1'b0;
`ifdef ARB_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    to_err_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (snp_wins_c) begin
          snp_req_ready = 1'b1;
          msg_d         = snp_req_msg;
          addr_d        = snp_req_addr;
          src_d         = 1'b1;
          valid_d       = 1'b1;
          busy_d        = 1'b1;
          state_d       = ISSUE;
          if (l1_req_valid && (streak_q != STREAK_W'(MAX_SNOOP_STREAK))) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else if (l1_req_valid) begin
          l1_req_ready = 1'b1;
          msg_d        = l1_req_msg;
          addr_d       = l1_req_addr;
          src_d        = 1'b0;
          valid_d      = 1'b1;
          busy_d       = 1'b1;
          state_d      = ISSUE;
          streak_d     = '0;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef ARB_TIMEOUT_EN
        to_cnt_d = '0;
`endif
      end
      WAIT: begin
        if (fsm_done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        // Expiry on the last allowed WAIT cycle; a coincident done takes priority.
        else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          state_d  = IDLE;
          busy_d   = 1'b0;
          to_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
`endif
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
    // No handshake may complete while reset is held.
    if (rst) begin
      l1_req_ready  = 1'b0;
      snp_req_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      msg_q    <= '0;
      addr_q   <= '0;
      src_q    <= 1'b0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      streak_q <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      addr_q   <= addr_d;
      src_q    <= src_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      streak_q <= streak_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  // Watchdog compiled out; the limit parameter has no effect.
  assign timeout_err = 1'b0 & (TIMEOUT_CYC == 32'd0);
`endif

  assign fsm_valid = valid_q;
  assign fsm_msg   = msg_q;
  assign fsm_addr  = addr_q;
  assign grant_src = src_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Directed plus randomized bench for cache_req_arbiter against a cycle-age reference model.
// Honours ARB_TIMEOUT_EN the same way as the design.
module tb_cache_req_arbiter;

  localparam int unsigned MSG_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int          MAXS   = 2;
  localparam int          TOC    = 16;

  localparam logic [3:0] READ_REQ_L1_D     = 4'h1;
  localparam logic [3:0] WRITE_REQ_L1_D    = 4'h2;
  localparam logic [3:0] SNOOP_READ_REQ    = 4'h8;
  localparam logic [3:0] SNOOP_INVALID_CMD = 4'h9;

  logic              clk = 1'b0;
  logic              rst;
  logic              l1_req_valid, l1_req_ready, snp_req_valid, snp_req_ready;
  logic [MSG_W-1:0]  l1_req_msg, snp_req_msg, fsm_msg;
  logic [ADDR_W-1:0] l1_req_addr, snp_req_addr, fsm_addr;
  logic              fsm_valid, fsm_done, grant_src, busy, timeout_err;

  cache_req_arbiter #(
    .MSG_W(MSG_W), .ADDR_W(ADDR_W), .MAX_SNOOP_STREAK(MAXS), .TIMEOUT_CYC(TOC)
  ) dut (
    .clk(clk), .rst(rst),
    .l1_req_valid(l1_req_valid), .l1_req_ready(l1_req_ready),
    .l1_req_msg(l1_req_msg), .l1_req_addr(l1_req_addr),
    .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready),
    .snp_req_msg(snp_req_msg), .snp_req_addr(snp_req_addr),
    .fsm_valid(fsm_valid), .fsm_msg(fsm_msg), .fsm_addr(fsm_addr),
    .fsm_done(fsm_done), .grant_src(grant_src), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: age = cycles since acceptance (0 = nothing in flight), plus grant history.
  int          age = 0;
  int          streak = 0;
  logic        to_pend = 1'b0;
  logic [3:0]  m_msg = '0;
  logic [31:0] m_addr = '0;
  logic        m_src = 1'b0;
  logic        grants[$];
  logic        gl, gs, saw_to;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic l1v, input logic [3:0] l1m, input logic [31:0] l1a,
                       input logic sv, input logic [3:0] sm, input logic [31:0] sa,
                       input logic dn, output logic o_gl, output logic o_gs);
    logic idle, sw, lw;
    l1_req_valid = l1v; l1_req_msg = l1m; l1_req_addr = l1a;
    snp_req_valid = sv; snp_req_msg = sm; snp_req_addr = sa;
    fsm_done = dn;
    #1;
    idle = (age == 0);
    sw   = idle && sv && !(l1v && streak == MAXS);
    lw   = idle && l1v && !sw;
    chk("l1_req_ready", 64'(l1_req_ready), 64'(lw));
    chk("snp_req_ready", 64'(snp_req_ready), 64'(sw));
    chk("fsm_valid", 64'(fsm_valid), 64'(age == 1));
    chk("busy", 64'(busy), 64'(age >= 1));
    chk("timeout_err", 64'(timeout_err), 64'(to_pend));
    if (age >= 1) begin
      chk("fsm_msg", 64'(fsm_msg), 64'(m_msg));
      chk("fsm_addr", 64'(fsm_addr), 64'(m_addr));
      chk("grant_src", 64'(grant_src), 64'(m_src));
    end
    if (l1_req_ready) grants.push_back(1'b0);
    if (snp_req_ready) grants.push_back(1'b1);
    o_gl = lw;
    o_gs = sw;
    to_pend = 1'b0;
    if (idle) begin
      if (sw) begin
        age = 1; m_msg = sm; m_addr = sa; m_src = 1'b1;
        if (l1v && streak < MAXS) streak++;
      end else if (lw) begin
        age = 1; m_msg = l1m; m_addr = l1a; m_src = 1'b0;
        streak = 0;
      end
    end else if (age >= 2 && dn) begin
      age = 0;
    end
`ifdef ARB_TIMEOUT_EN
    else if (age == TOC + 1) begin
      age = 0;
      to_pend = 1'b1;
    end
`endif
    else begin
      age++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_fsm_valid", 64'(fsm_valid), 64'd0);
    chk("rst_l1_ready", 64'(l1_req_ready), 64'd0);
    chk("rst_snp_ready", 64'(snp_req_ready), 64'd0);
    chk("rst_timeout_err", 64'(timeout_err), 64'd0);
    chk("rst_fsm_msg", 64'(fsm_msg), 64'd0);
    chk("rst_fsm_addr", 64'(fsm_addr), 64'd0);
    chk("rst_grant_src", 64'(grant_src), 64'd0);
    age = 0; streak = 0; to_pend = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  logic        rl_v, rs_v;
  logic [3:0]  rl_m, rs_m;
  logic [31:0] rl_a, rs_a;

  initial begin
    rst = 1'b1;
    l1_req_valid = 1'b0; l1_req_msg = '0; l1_req_addr = '0;
    snp_req_valid = 1'b0; snp_req_msg = '0; snp_req_addr = '0;
    fsm_done = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // L1 alone: accept, issue, two WAIT cycles with done on the second, then idle.
    cycle(1'b1, READ_REQ_L1_D, 32'h100, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    chk("t1_fsm_addr", 64'(fsm_addr), 64'h100);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);

    // Simultaneous valids: snoop first, L1 the cycle after done.
    grants.delete();
    cycle(1'b1, WRITE_REQ_L1_D, 32'h200, 1'b1, SNOOP_READ_REQ, 32'h300, 1'b0, gl, gs);
    cycle(1'b1, WRITE_REQ_L1_D, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    chk("t2_grant_src", 64'(grant_src), 64'd1);
    cycle(1'b1, WRITE_REQ_L1_D, 32'h200, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b1, WRITE_REQ_L1_D, 32'h200, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    chk("t2_grant_count", 64'(grants.size()), 64'd2);
    if (grants.size() == 2) begin
      chk("t2_first_snoop", 64'(grants[0]), 64'd1);
      chk("t2_second_l1", 64'(grants[1]), 64'd0);
    end

    // Spurious done in IDLE and in ISSUE must be ignored.
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b1, READ_REQ_L1_D, 32'h400, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    chk("t6_still_busy", 64'(busy), 64'd1);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);

    // No done after issue, with an L1 request left pending.
    saw_to = 1'b0;
    cycle(1'b0, 4'h0, 32'h0, 1'b1, SNOOP_INVALID_CMD, 32'h500, 1'b0, gl, gs);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, READ_REQ_L1_D, 32'h600, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
      saw_to = saw_to | timeout_err;
    end
`ifdef ARB_TIMEOUT_EN
    chk("t5_timeout_seen", 64'(saw_to), 64'd1);
`else
    chk("t5_busy_held", 64'(busy), 64'd1);
    chk("t5_no_timeout", 64'(saw_to), 64'd0);
`endif

    // Reset mid-WAIT; the pending L1 request is accepted again afterwards.
    do_reset();
    grants.delete();
    cycle(1'b1, READ_REQ_L1_D, 32'h600, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    chk("t4_reaccept", 64'(grants.size()), 64'd1);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, gl, gs);
    cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);

    // Streak limit 2 with both sources always requesting.
    grants.delete();
    for (int i = 0; i < 18; i++) begin
      cycle(1'b1, WRITE_REQ_L1_D, 32'h700, 1'b1, SNOOP_READ_REQ, 32'h800, 1'b1, gl, gs);
    end
    chk("t3_grant_count", 64'(grants.size()), 64'd6);
    if (grants.size() == 6) begin
      logic exp_order [6];
      exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) chk("t3_grant_order", 64'(grants[i]), 64'(exp_order[i]));
    end

    // Randomized traffic with legal hold/drop behaviour on both sources.
    rl_v = 1'b0; rs_v = 1'b0; rl_m = '0; rs_m = '0; rl_a = '0; rs_a = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!rl_v && $urandom_range(0, 9) < 4) begin
        rl_v = 1'b1; rl_m = 4'($urandom); rl_a = $urandom;
      end else if (rl_v && $urandom_range(0, 19) == 0) begin
        rl_v = 1'b0;
      end
      if (!rs_v && $urandom_range(0, 9) < 4) begin
        rs_v = 1'b1; rs_m = 4'($urandom); rs_a = $urandom;
      end else if (rs_v && $urandom_range(0, 19) == 0) begin
        rs_v = 1'b0;
      end
      cycle(rl_v, rl_m, rl_a, rs_v, rs_m, rs_a, ($urandom_range(0, 2) == 0), gl, gs);
      if (gl) rl_v = 1'b0;
      if (gs) rs_v = 1'b0;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b1, gl, gs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
